// File: rtl/mem_access_ctrl.sv
// Load/store access controller: alignment check, word-aligned bus request with byte enables,
// ack/timeout handling and sign/zero-extended load return.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_t;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  acc_type;
    logic [1:0]  acc_off;

    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] rdata_ext;

    always_comb begin
        is_store   = (req_type >= 3'd5);
        is_half    = (req_type == 3'd2) || (req_type == 3'd3) || (req_type == 3'd6);
        is_word    = (req_type == 3'd4) || (req_type == 3'd7);
        misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        case (req_type)
            3'd5: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            3'd6: begin
                be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{acc_off, 3'b000} +: 8];
        ld_half = mem_rdata[{acc_off[1], 4'b0000} +: 16];
        case (acc_type)
            3'd0:    rdata_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    rdata_ext = {24'h0, ld_byte};
            3'd2:    rdata_ext = {{16{ld_half[15]}}, ld_half};
            3'd3:    rdata_ext = {16'h0, ld_half};
            3'd4:    rdata_ext = mem_rdata;
            default: rdata_ext = 32'h0;  // stores return no data
        endcase
    end

    assign req_ready = (state == StIdle);
    assign stall     = req_valid & ~resp_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            cnt        <= 8'h0;
            acc_type   <= 3'd0;
            acc_off    <= 2'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            adel       <= 1'b0;
            ades       <= 1'b0;
            bus_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_be     <= 4'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        acc_type <= req_type;
                        acc_off  <= req_addr[1:0];
                        if (misaligned) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            adel       <= ~is_store;
                            ades       <= is_store;
                        end else begin
                            state     <= StBus;
                            cnt       <= 8'h0;
                            mem_req   <= 1'b1;
                            mem_wr    <= is_store;
                            mem_be    <= be_next;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= wdata_next;
                        end
                    end
                end
                StBus: begin
                    // ack takes priority over a timeout in the same cycle
                    if (mem_ack) begin
                        state      <= StResp;
                        mem_req    <= 1'b0;
                        mem_wr     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_ext;
                    end else if (cnt == CntLast) begin
                        state      <= StResp;
                        mem_req    <= 1'b0;
                        mem_wr     <= 1'b0;
                        resp_valid <= 1'b1;
                        bus_err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                StResp: begin
                    state      <= StIdle;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                    adel       <= 1'b0;
                    ades       <= 1'b0;
                    bus_err    <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized load/store
// traffic against a byte-addressed memory model.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        adel;
    logic        ades;
    logic        bus_err;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [logic [31:0]];

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .adel       (adel),
        .ades       (ades),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (!ref_mem.exists(a)) ref_mem[a] = 8'($urandom);
        return ref_mem[a];
    endfunction

    function automatic int size_of(input logic [2:0] t);
        if (t == 3'd4 || t == 3'd7) return 4;
        if (t == 3'd2 || t == 3'd3 || t == 3'd6) return 2;
        return 1;
    endfunction

    // Expected load result straight from the memory model.
    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        int sz = size_of(t);
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rd_byte(a + 32'(i));
        if (t == 3'd0) v = 32'($signed(v[7:0]));
        if (t == 3'd2) v = 32'($signed(v[15:0]));
        return v;
    endfunction

    // One transaction; entered and left at a negedge with the DUT idle.
    task automatic do_txn(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_cyc, input bit hold, output logic [31:0] rd);
        bit          st  = (t >= 3'd5);
        int          sz  = size_of(t);
        bit          mis = ((a % sz) != 0);
        bit          acked = 1'b0;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd = 32'h0;
        logic [31:0] wa = {a[31:2], 2'b00};
        int          off = int'(a[1:0]);

        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        #1 check("stall_req", 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (mis) begin
            check("mis_resp_valid", 32'(resp_valid), 32'd1);
            check("mis_mem_req", 32'(mem_req), 32'd0);
            check("mis_adel", 32'(adel), 32'(!st));
            check("mis_ades", 32'(ades), 32'(st));
            check("mis_bus_err", 32'(bus_err), 32'd0);
            check("mis_rdata", resp_rdata, 32'h0);
        end else begin
            exp_be = 4'hF;
            for (int i = 0; i < 4; i++) begin
                if (st) exp_be[i] = (i >= off) && (i < off + sz);
                exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
            end
            if (!st) exp_rd = ref_load(t, a);
            for (int c = 1; c <= int'(TO); c++) begin
                check("bus_mem_req", 32'(mem_req), 32'd1);
                check("bus_resp_valid", 32'(resp_valid), 32'd0);
                check("bus_stall", 32'(stall), 32'd1);
                check("bus_addr", mem_addr, wa);
                check("bus_be", 32'(mem_be), 32'(exp_be));
                check("bus_wr", 32'(mem_wr), 32'(st));
                if (st) check("bus_wdata", mem_wdata, exp_wd);
                if (c == ack_cyc) begin
                    mem_ack = 1'b1;
                    for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = rd_byte(wa + 32'(i));
                    acked = 1'b1;
                end
                @(posedge clk);
                #1 mem_ack = 1'b0;
                mem_rdata = $urandom;
                @(negedge clk);
                if (acked) break;
            end
            if (acked && st)
                for (int i = 0; i < sz; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
            if (!acked) exp_rd = 32'h0;
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_mem_req", 32'(mem_req), 32'd0);
            check("resp_rdata", resp_rdata, exp_rd);
            check("resp_bus_err", 32'(bus_err), 32'(!acked));
            check("resp_addr_err", 32'({adel, ades}), 32'd0);
        end
        check("resp_stall", 32'(stall), 32'd0);
        check("resp_not_ready", 32'(req_ready), 32'd0);
        rd = resp_rdata;
        if (!hold) req_valid = 1'b0;
        @(negedge clk);
        check("post_resp_valid", 32'(resp_valid), 32'd0);
        check("post_flags", 32'({adel, ades, bus_err}), 32'd0);
        check("post_rdata", resp_rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_type  = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_outs", 32'({mem_req, mem_wr, resp_valid, adel, ades, bus_err}), 32'd0);
        check("rst_bus", 32'(mem_be) | mem_addr | mem_wdata | resp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // LB / LBU of a negative top byte
        ref_mem[32'h1000] = 8'h00;
        ref_mem[32'h1001] = 8'hFF;
        ref_mem[32'h1002] = 8'hFF;
        ref_mem[32'h1003] = 8'h80;
        do_txn(3'd0, 32'h1003, 32'h0, 1, 1'b0, rd);
        check("lb_neg", rd, 32'hFFFF_FF80);
        do_txn(3'd1, 32'h1003, 32'h0, 1, 1'b0, rd);
        check("lbu_neg", rd, 32'h0000_0080);

        // SH upper half with two wait states
        do_txn(3'd6, 32'h2002, 32'h1234_ABCD, 3, 1'b0, rd);
        do_txn(3'd3, 32'h2002, 32'h0, 1, 1'b0, rd);
        check("sh_readback", rd, 32'h0000_ABCD);

        // Misaligned
        do_txn(3'd4, 32'h3001, 32'h0, 1, 1'b0, rd);
        do_txn(3'd6, 32'h3001, 32'h5555, 1, 1'b0, rd);

        // Timeout and ack-on-last-cycle
        do_txn(3'd4, 32'h40, 32'h0, 0, 1'b0, rd);
        do_txn(3'd4, 32'h40, 32'h0, int'(TO), 1'b0, rd);

        // Reset in the middle of a bus access
        req_valid = 1'b1;
        req_type  = 3'd7;
        req_addr  = 32'h80;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        check("mid_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_outs", 32'({mem_req, mem_wr, resp_valid, adel, ades, bus_err}), 32'd0);
        check("mid_rst_bus", 32'(mem_be) | mem_addr | mem_wdata | resp_rdata, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("mid_no_resp", 32'(resp_valid), 32'd0);
        do_txn(3'd4, 32'h80, 32'h0, 2, 1'b0, rd);

        // Back-to-back store then load, request held through RESP
        do_txn(3'd7, 32'h10, 32'hCAFE_F00D, 1, 1'b1, rd);
        do_txn(3'd4, 32'h10, 32'h0, 1, 1'b0, rd);
        check("b2b_lw", rd, 32'hCAFE_F00D);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  t   = 3'($urandom_range(0, 7));
            logic [31:0] a   = 32'h100 + 32'($urandom_range(0, 31));
            int          ack = int'($urandom_range(0, 5));
            bit          hld = 1'($urandom);
            int          gap = hld ? 0 : int'($urandom_range(0, 2));
            do_txn(t, a, $urandom, ack, hld, rd);
            repeat (gap) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
